// File: rtl/clock_enable_generator.sv
// Multi-channel fractional clock-enable generator.
// Per-channel num/den phase accumulators gated by a PLL-lock qualifier.
module clock_enable_generator #(
  parameter int NUM_CH      = 4,
  parameter int CTR_W       = 16,
  parameter int LOCK_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pll_locked,
  input  logic              cfg_we,
  input  logic [3:0]        cfg_ch,
  input  logic [CTR_W-1:0]  cfg_num,
  input  logic [CTR_W-1:0]  cfg_den,
  input  logic              cfg_en,
  output logic              ready,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] sq
);

  localparam int LW = $clog2(LOCK_CYCLES + 1);
  localparam logic [LW-1:0] LOCK_MAX = LW'(LOCK_CYCLES);

  logic [LW-1:0] lock_cnt;
  logic [LW-1:0] lock_nxt;
  logic          cfg_hit;

  assign lock_nxt = (lock_cnt == LOCK_MAX) ? lock_cnt
                                           : lock_cnt + LW'(1);
  assign cfg_hit  = cfg_we && (32'(cfg_ch) < NUM_CH);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_cnt <= '0;
      ready    <= 1'b0;
    end else if (!pll_locked) begin
      lock_cnt <= '0;
      ready    <= 1'b0;
    end else begin
      lock_cnt <= lock_nxt;
      ready    <= (lock_nxt == LOCK_MAX);
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CTR_W-1:0] num;
    logic [CTR_W-1:0] den;
    logic [CTR_W-1:0] acc;
    logic [CTR_W-1:0] n;
    logic [CTR_W:0]   sum;
    logic [CTR_W:0]   rem;
    logic             en;
    logic             t_q;
    logic             s_q;
    logic             wr;
    logic             act;

    assign wr  = cfg_hit && (cfg_ch == 4'(i));
    assign act = ready && en && (den != '0);
    // Clamp so the accumulator wraps at most once per edge.
    assign n   = (num < den) ? num : den;
    assign sum = {1'b0, acc} + {1'b0, n};
    assign rem = sum - {1'b0, den};

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        num <= '0;
        den <= '0;
        en  <= 1'b0;
        acc <= '0;
        t_q <= 1'b0;
        s_q <= 1'b0;
      end else if (wr) begin
        num <= cfg_num;
        den <= cfg_den;
        en  <= cfg_en;
        acc <= '0;
        t_q <= 1'b0;
        s_q <= 1'b0;
      end else if (!pll_locked) begin
        acc <= '0;
        t_q <= 1'b0;
        s_q <= 1'b0;
      end else if (act) begin
        if (sum >= {1'b0, den}) begin
          acc <= rem[CTR_W-1:0];
          t_q <= 1'b1;
          s_q <= ~s_q;
        end else begin
          acc <= sum[CTR_W-1:0];
          t_q <= 1'b0;
        end
      end else begin
        t_q <= 1'b0;
      end
    end

    assign tick[i] = t_q;
    assign sq[i]   = s_q;
  end

endmodule

// File: tb/tb_clock_enable_generator.sv
// Bench for clock_enable_generator: ratio-based reference model
// compared every cycle, plus directed literal checks.
module tb_clock_enable_generator;

  localparam int NUM_CH = 4;
  localparam int CTR_W  = 16;
  localparam int LOCK   = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              pll_locked;
  logic              cfg_we;
  logic [3:0]        cfg_ch;
  logic [CTR_W-1:0]  cfg_num;
  logic [CTR_W-1:0]  cfg_den;
  logic              cfg_en;
  logic              ready;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] sq;

  int vecs  = 0;
  int fails = 0;

  clock_enable_generator #(
    .NUM_CH(NUM_CH),
    .CTR_W(CTR_W),
    .LOCK_CYCLES(LOCK)
  ) dut (
    .clk(clk),
    .reset(reset),
    .pll_locked(pll_locked),
    .cfg_we(cfg_we),
    .cfg_ch(cfg_ch),
    .cfg_num(cfg_num),
    .cfg_den(cfg_den),
    .cfg_en(cfg_en),
    .ready(ready),
    .tick(tick),
    .sq(sq)
  );

  always #5 clk = ~clk;

  // Reference: after k counting edges a channel has wrapped
  // floor(k*n/den) times; tick = that count stepped, sq = its parity.
  int                mlock = 0;
  logic              m_ready = 1'b0;
  logic [NUM_CH-1:0] m_tick = '0;
  logic [NUM_CH-1:0] m_sq = '0;
  longint            mk   [NUM_CH] = '{default: 0};
  longint            mnum [NUM_CH] = '{default: 0};
  longint            mden [NUM_CH] = '{default: 0};
  bit                men  [NUM_CH] = '{default: 0};

  function automatic longint wraps(input int c, input longint k);
    longint n;
    if (mden[c] == 0) return 0;
    n = (mnum[c] < mden[c]) ? mnum[c] : mden[c];
    return (k * n) / mden[c];
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mlock   = 0;
      m_ready = 1'b0;
      m_tick  = '0;
      m_sq    = '0;
      for (int c = 0; c < NUM_CH; c++) begin
        mk[c] = 0; mnum[c] = 0; mden[c] = 0; men[c] = 0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        m_tick[c] = 1'b0;
        if (cfg_we && int'(cfg_ch) == c) begin
          mnum[c] = longint'(cfg_num);
          mden[c] = longint'(cfg_den);
          men[c]  = cfg_en;
          mk[c]   = 0;
        end else if (!pll_locked) begin
          mk[c] = 0;
        end else if (m_ready && men[c] && mden[c] != 0) begin
          mk[c] = mk[c] + 1;
          m_tick[c] = (wraps(c, mk[c]) != wraps(c, mk[c] - 1));
        end
        m_sq[c] = ((wraps(c, mk[c]) % 2) == 1);
      end
      if (pll_locked) begin
        mlock   = (mlock + 1 > LOCK) ? LOCK : mlock + 1;
        m_ready = (mlock >= LOCK);
      end else begin
        mlock   = 0;
        m_ready = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    vecs++;
    if (ready !== m_ready) begin
      fails++;
      $display("FAIL model_ready t=%0t dut=%b exp=%b", $time, ready, m_ready);
    end
    vecs++;
    if (tick !== m_tick) begin
      fails++;
      $display("FAIL model_tick t=%0t dut=%b exp=%b", $time, tick, m_tick);
    end
    vecs++;
    if (sq !== m_sq) begin
      fails++;
      $display("FAIL model_sq t=%0t dut=%b exp=%b", $time, sq, m_sq);
    end
  end

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s t=%0t got=%0d expected=%0d", name, $time, act, exp);
    end
  endtask

  task automatic edges(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cfg(input int ch, input int num, input int den,
                     input bit en);
    cfg_we  = 1'b1;
    cfg_ch  = 4'(ch);
    cfg_num = CTR_W'(num);
    cfg_den = CTR_W'(den);
    cfg_en  = en;
    @(negedge clk);
    cfg_we  = 1'b0;
  endtask

  initial begin
    int cnt;
    int pos [4];
    int acc_sq;

    reset = 1'b1; pll_locked = 1'b0;
    cfg_we = 1'b0; cfg_ch = '0; cfg_num = '0; cfg_den = '0; cfg_en = 1'b0;
    edges(2);
    check("rst_ready", 64'(ready), 0);
    check("rst_tick", 64'(tick), 0);
    check("rst_sq", 64'(sq), 0);

    // Lock qualification, with ch0 configured before ready.
    reset = 1'b0;
    pll_locked = 1'b1;
    cfg(0, 1, 50, 1'b1);
    edges(6);
    check("lock_e7", 64'(ready), 0);
    edges(1);
    check("lock_e8", 64'(ready), 1);
    edges(11);
    pll_locked = 1'b0;
    edges(1);
    check("drop_ready", 64'(ready), 0);
    check("drop_tick", 64'(tick), 0);
    check("drop_sq", 64'(sq), 0);
    pll_locked = 1'b1;
    edges(7);
    check("relock_e7", 64'(ready), 0);
    edges(1);
    check("relock_e8", 64'(ready), 1);

    // ch0 config retained: divide by 50.
    edges(49);
    check("ch0_pre", 64'(tick[0]), 0);
    edges(1);
    check("ch0_first", 64'(tick[0]), 1);
    check("ch0_sq1", 64'(sq[0]), 1);
    edges(49);
    check("ch0_gap", 64'(tick[0]), 0);
    edges(1);
    check("ch0_second", 64'(tick[0]), 1);
    check("ch0_sq2", 64'(sq[0]), 0);

    // Fractional 3/7.
    cfg(1, 3, 7, 1'b1);
    cnt = 0;
    for (int k = 1; k <= 700; k++) begin
      edges(1);
      if (tick[1]) begin
        if (cnt < 4) pos[cnt] = k;
        cnt++;
      end
    end
    check("frac_t0", 64'(pos[0]), 3);
    check("frac_t1", 64'(pos[1]), 5);
    check("frac_t2", 64'(pos[2]), 7);
    check("frac_t3", 64'(pos[3]), 10);
    check("frac_count", 64'(cnt), 300);

    // n clamped to den: continuous tick, sq toggles each cycle.
    cfg(3, 9, 5, 1'b1);
    for (int k = 1; k <= 6; k++) begin
      edges(1);
      check("sat_tick", 64'(tick[3]), 1);
      check("sat_sq", 64'(sq[3]), 64'(k % 2));
    end

    // num=0, then den=0: silent.
    cfg(3, 0, 5, 1'b1);
    cnt = 0; acc_sq = 0;
    for (int k = 0; k < 20; k++) begin
      edges(1);
      cnt += int'(tick[3]);
      acc_sq += int'(sq[3]);
    end
    check("num0_ticks", 64'(cnt), 0);
    check("num0_sq", 64'(acc_sq), 0);
    cfg(3, 3, 0, 1'b1);
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      edges(1);
      cnt += int'(tick[3]);
    end
    check("den0_ticks", 64'(cnt), 0);

    // Out-of-range channel index.
    cfg(NUM_CH, 1, 2, 1'b1);
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      edges(1);
      cnt += int'(tick[3]);
    end
    check("badch_ticks", 64'(cnt), 0);

    // Reconfigure ch2 on the edge its tick is due.
    cfg(2, 1, 10, 1'b1);
    edges(9);
    cfg(2, 1, 4, 1'b1);
    check("recfg_tick", 64'(tick[2]), 0);
    check("recfg_sq", 64'(sq[2]), 0);
    edges(3);
    check("recfg_gap", 64'(tick[2]), 0);
    edges(1);
    check("recfg_next", 64'(tick[2]), 1);
    check("recfg_sq1", 64'(sq[2]), 1);

    // Async reset between edges.
    @(posedge clk);
    #1;
    check("pre_rst_ready", 64'(ready), 1);
    #1;
    reset = 1'b1;
    #1;
    check("arst_ready", 64'(ready), 0);
    check("arst_tick", 64'(tick), 0);
    check("arst_sq", 64'(sq), 0);
    @(negedge clk);
    reset = 1'b0;
    edges(7);
    check("arst_lock_e7", 64'(ready), 0);
    edges(1);
    check("arst_lock_e8", 64'(ready), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
